button_press: RTL and testbench

Input-side counterpart to the LED blinkers on the icestick boards. It conditions one raw push-button pin through a synchronizer and a debouncer. It then classifies each press as short or long and emits one-cycle event pulses. Downstream logic, such as a blink-mode selector, consumes the clean level and events without needing its own timing.

---
 rtl/button_press.sv | 111 +++++++++++
 tb/tb_button_press.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_press.sv
// button_press: conditions a raw active-low push-button pin and classifies
// each debounced press as short or long.
// Outputs are a clean held level plus one-cycle short/long event pulses.
module button_press #(
    parameter int DEBOUNCE_COUNT = 120_000,
    parameter int LONG_COUNT     = 12_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic pressed,
    output logic short_press,
    output logic long_press
);

    localparam int DW = $clog2(DEBOUNCE_COUNT);
    localparam int LW = $clog2(LONG_COUNT);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_COUNT - 1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        LONG
    } state_t;

    logic          sync1;
    logic          sync;
    logic          stable;
    logic [DW-1:0] db_cnt;
    logic [LW-1:0] hold_cnt;
    state_t        state;

    // The debounced state flips on this cycle; used so the FSM reacts on the
    // same edge that pressed changes.
    logic db_flip;
    logic press_edge;
    logic release_edge;

    assign db_flip      = (sync != stable) && (db_cnt == DB_LAST);
    assign press_edge   = db_flip && !sync;
    assign release_edge = db_flip && sync;

    // Two-flop synchronizer; idles at 1 (released) so reset never looks like a press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            sync  <= 1'b1;
        end else begin
            sync1 <= btn_n;
            sync  <= sync1;
        end
    end

    // Debouncer: sync must disagree with stable for DEBOUNCE_COUNT cycles in a row.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable  <= 1'b1;
            pressed <= 1'b0;
            db_cnt  <= '0;
        end else if (sync == stable) begin
            db_cnt <= '0;
        end else if (db_flip) begin
            stable  <= sync;
            pressed <= ~sync;
            db_cnt  <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // Press classifier; release is tested before the long threshold so it wins a tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            short_press <= 1'b0;
            long_press  <= 1'b0;
        end else begin
            short_press <= 1'b0;
            long_press  <= 1'b0;
            case (state)
                IDLE: begin
                    if (press_edge) begin
                        hold_cnt <= '0;
                        state    <= HELD;
                    end
                end
                HELD: begin
                    if (release_edge) begin
                        short_press <= 1'b1;
                        state       <= IDLE;
                    end else if (hold_cnt == LONG_LAST) begin
                        long_press <= 1'b1;
                        state      <= LONG;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                LONG: begin
                    // hold_cnt stays frozen until the button is let go
                    if (release_edge) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_button_press.sv
// Directed bench for button_press with DEBOUNCE_COUNT = 4, LONG_COUNT = 20.
// Edge numbering: btn_n is driven just after edge 0; edge e is the e-th rising
// clk edge after that, and outputs are sampled 1 ns after each edge.
module tb_button_press;

    logic clk;
    logic rst;
    logic btn_n;
    logic pressed;
    logic short_press;
    logic long_press;

    int n_vec;
    int n_err;

    button_press #(
        .DEBOUNCE_COUNT(4),
        .LONG_COUNT    (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_n      (btn_n),
        .pressed    (pressed),
        .short_press(short_press),
        .long_press (long_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [2:0] exp;
        rst   = 1'b0;
        btn_n = 1'b1;
        #3;
        exp = 3'b000;
        n_vec++;
        if ({pressed, short_press, long_press} !== exp) begin
            n_err++;
            $display("FAIL reset_idle got %b want %b", {pressed, short_press, long_press}, exp);
        end
        // button held while in reset must not leak through
        btn_n = 1'b0;
        for (int e = 1; e <= 10; e++) step();
        n_vec++;
        if ({pressed, short_press, long_press} !== exp) begin
            n_err++;
            $display("FAIL reset_held got %b want %b", {pressed, short_press, long_press}, exp);
        end
        btn_n = 1'b1;
        step();
        rst = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            n_vec++;
            if ({pressed, short_press, long_press} !== exp) begin
                n_err++;
                $display("FAIL reset_release e=%0d got %b want %b", e, {pressed, short_press, long_press}, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [2:0] exp;
        btn_n = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            step();
            btn_n = (e >= 3);
            exp = 3'b000;
            n_vec++;
            if ({pressed, short_press, long_press} !== exp) begin
                n_err++;
                $display("FAIL glitch e=%0d got %b want %b", e, {pressed, short_press, long_press}, exp);
            end
        end
    endtask

    task automatic test_short();
        logic [2:0] exp;
        btn_n = 1'b0;
        for (int e = 1; e <= 30; e++) begin
            step();
            btn_n = (e >= 15);
            exp = {(e >= 6 && e < 21), (e == 21), 1'b0};
            n_vec++;
            if ({pressed, short_press, long_press} !== exp) begin
                n_err++;
                $display("FAIL short e=%0d got %b want %b", e, {pressed, short_press, long_press}, exp);
            end
        end
    endtask

    task automatic test_long();
        logic [2:0] exp;
        btn_n = 1'b0;
        for (int e = 1; e <= 54; e++) begin
            step();
            btn_n = (e >= 40);
            exp = {(e >= 6 && e < 46), 1'b0, (e == 26)};
            n_vec++;
            if ({pressed, short_press, long_press} !== exp) begin
                n_err++;
                $display("FAIL long e=%0d got %b want %b", e, {pressed, short_press, long_press}, exp);
            end
        end
    endtask

    task automatic test_bounce();
        logic [2:0]  exp;
        logic [47:0] pat;
        // bit c = btn_n during cycle c: 2-cycle bounce, 14-cycle solid low,
        // 1-cycle bounce on release, then settled high from cycle 26
        pat = '1;
        for (int c = 0; c < 2; c++) pat[c] = 1'b0;
        for (int c = 4; c < 6; c++) pat[c] = 1'b0;
        for (int c = 8; c < 22; c++) pat[c] = 1'b0;
        pat[23] = 1'b0;
        pat[25] = 1'b0;
        btn_n = pat[0];
        for (int e = 1; e <= 40; e++) begin
            step();
            btn_n = pat[e];
            exp = {(e >= 14 && e < 32), (e == 32), 1'b0};
            n_vec++;
            if ({pressed, short_press, long_press} !== exp) begin
                n_err++;
                $display("FAIL bounce e=%0d got %b want %b", e, {pressed, short_press, long_press}, exp);
            end
        end
    endtask

    task automatic test_threshold();
        logic [2:0] exp;
        int low;
        // btn_n low 19 -> pressed 19 cycles, short at 25
        // btn_n low 20 -> release lands on the threshold edge 26: release wins
        // btn_n low 21 -> long at 26, pressed falls at 27 with no short
        for (int k = 0; k < 3; k++) begin
            low   = 19 + k;
            btn_n = 1'b0;
            for (int e = 1; e <= 36; e++) begin
                step();
                btn_n = (e >= low);
                exp = {(e >= 6 && e < low + 6),
                       (low <= 20 && e == low + 6),
                       (low >= 21 && e == 26)};
                n_vec++;
                if ({pressed, short_press, long_press} !== exp) begin
                    n_err++;
                    $display("FAIL threshold low=%0d e=%0d got %b want %b", low, e, {pressed, short_press, long_press}, exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] exp;
        btn_n = 1'b0;
        for (int e = 1; e <= 28; e++) begin
            step();
            exp = {(e >= 6), 1'b0, (e == 26)};
            n_vec++;
            if ({pressed, short_press, long_press} !== exp) begin
                n_err++;
                $display("FAIL midrst_enter e=%0d got %b want %b", e, {pressed, short_press, long_press}, exp);
            end
        end
        // now in LONG with the button held; reset between edges
        #2;
        rst = 1'b0;
        #1;
        exp = 3'b000;
        n_vec++;
        if ({pressed, short_press, long_press} !== exp) begin
            n_err++;
            $display("FAIL midrst_async got %b want %b", {pressed, short_press, long_press}, exp);
        end
        step();
        step();
        n_vec++;
        if ({pressed, short_press, long_press} !== exp) begin
            n_err++;
            $display("FAIL midrst_hold got %b want %b", {pressed, short_press, long_press}, exp);
        end
        #3;
        rst = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            step();
            exp = {(e >= 6), 1'b0, (e == 26)};
            n_vec++;
            if ({pressed, short_press, long_press} !== exp) begin
                n_err++;
                $display("FAIL midrst_repress e=%0d got %b want %b", e, {pressed, short_press, long_press}, exp);
            end
        end
        btn_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            step();
            exp = {(e < 6), 1'b0, 1'b0};
            n_vec++;
            if ({pressed, short_press, long_press} !== exp) begin
                n_err++;
                $display("FAIL midrst_release e=%0d got %b want %b", e, {pressed, short_press, long_press}, exp);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        btn_n = 1'b1;
        test_reset();
        test_glitch();
        test_short();
        test_long();
        test_bounce();
        test_threshold();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
